sequence_checker: RTL

SEQUENCE_CHECKER -- requirements
Module: sequence_checker

---
 rtl/sequence_checker.sv | 126 ++++++++++++
 1 files changed

// File: rtl/sequence_checker.sv
// sequence_checker: locks onto the repeating 0,2,5,8,11,14 sample sequence and flags deviations
// Ports: clk; reset (async, active-high); in_valid/in_data (4-bit sample); clear (sync err_count clear);
//    locked, match, mismatch, lost_lock, expected[3:0], err_count[7:0] (all registered).
// Optional feature: define SEQ_CHECK_ERRCNT_EN to build the saturating err_count; otherwise err_count is 0.
module sequence_checker #(
   parameter int LOCK_CNT   = 3,
   parameter int UNLOCK_CNT = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [3:0] in_data,
   input  logic       clear,
   output logic       locked,
   output logic       match,
   output logic       mismatch,
   output logic       lost_lock,
   output logic [3:0] expected,
   output logic [7:0] err_count
);
   typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;
   localparam logic [2:0] LOCK_N   = 3'(LOCK_CNT);
   localparam logic [2:0] UNLOCK_N = 3'(UNLOCK_CNT);
   state_t     state, state_n;
   logic [3:0] expected_n;
   logic [2:0] good, good_n, bad, bad_n;
   logic       match_n, mismatch_n, lost_n;

   function automatic logic [3:0] nxt(input logic [3:0] v);
      case (v)
         4'd0:    nxt = 4'd2;
         4'd2:    nxt = 4'd5;
         4'd5:    nxt = 4'd8;
         4'd8:    nxt = 4'd11;
         4'd11:   nxt = 4'd14;
         default: nxt = 4'd0;
      endcase
   endfunction

   function automatic logic legal(input logic [3:0] v);
      legal = v inside {4'd0, 4'd2, 4'd5, 4'd8, 4'd11, 4'd14};
   endfunction

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state     <= HUNT;
         expected  <= '0;
         good      <= '0;
         bad       <= '0;
         locked    <= 1'b0;
         match     <= 1'b0;
         mismatch  <= 1'b0;
         lost_lock <= 1'b0;
      end else begin
         state     <= state_n;
         expected  <= expected_n;
         good      <= good_n;
         bad       <= bad_n;
         locked    <= state_n == LOCKED;
         match     <= match_n;
         mismatch  <= mismatch_n;
         lost_lock <= lost_n;
      end

   always_comb begin
      state_n    = state;
      expected_n = expected;
      good_n     = good;
      bad_n      = bad;
      if (in_valid)
         case (state)
            HUNT:
               if (legal(in_data)) begin
                  state_n    = SYNC;
                  expected_n = nxt(in_data);
                  good_n     = 3'd1;
               end
            SYNC:
               if (in_data == expected) begin
                  expected_n = nxt(expected);
                  good_n     = good + 3'd1;
                  if (good_n == LOCK_N) begin
                     state_n = LOCKED;
                     bad_n   = '0;
                  end
               end else if (legal(in_data)) begin
                  expected_n = nxt(in_data);
                  good_n     = 3'd1;
               end else begin
                  state_n = HUNT;
                  good_n  = '0;
               end
            default: begin
               // flywheel: keep predicting through errors so a single glitch does not lose phase
               expected_n = nxt(expected);
               bad_n      = (in_data == expected) ? 3'd0 : bad + 3'd1;
               if (bad_n == UNLOCK_N) begin
                  state_n = HUNT;
                  good_n  = '0;
                  bad_n   = '0;
               end
            end
         endcase
   end

   always_comb begin
      match_n    = in_valid && state == LOCKED && in_data == expected;
      mismatch_n = in_valid && state == LOCKED && in_data != expected;
      lost_n     = state == LOCKED && state_n == HUNT;
   end

`ifdef SEQ_CHECK_ERRCNT_EN
   // clear takes priority over a coincident mismatch
   always_ff @(posedge clk or posedge reset)
      if (reset)
         err_count <= '0;
      else if (clear)
         err_count <= '0;
      else if (mismatch_n && err_count != 8'hFF)
         err_count <= err_count + 8'd1;
`else
   logic unused_clear;
   assign unused_clear = clear;
   assign err_count    = '0;
`endif
endmodule
